if_id_pipe_ctrl: RTL and testbench
==================================

Name: if_id_pipe_ctrl

Overview:
- Consumer side of the hazard-detection control signals.
- Owns the PC register, the IF/ID pipeline register and the control-bit half of the ID/EX register.
- Applies stall (write-disable), flush (bubble insert) and branch redirect with a fixed priority.
- Keeps saturating stall and flush event counters for performance debug.
- Sits between instruction memory, the decoder and the EX stage of the 5-stage MIPS pipeline.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CTRL_W, 10, width of the ID/EX control bundle (RegWrite, MemRead, MemWrite, ALUOp, etc.).
- CNT_W, 16, width of each performance counter.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- pcwrite_i  in  1  1 = PC may advance; 0 = hold PC.
- ifid_write_i  in  1  1 = IF/ID loads; 0 = IF/ID holds.
- ifid_flush_i  in  1  squash the IF/ID contents.
- idex_flush_i  in  1  insert a bubble into the ID/EX control bits.
- branch_taken_i  in  1  redirect the PC to branch_target_i.
- branch_target_i  in  32  redirect address.
- instr_i  in  32  instruction memory data for the current pc_o.
- id_ctrl_i  in  CTRL_W  decoder control bundle for the instruction in ID.
- pc_o  out  32  current fetch PC.
- ifid_pc4_o  out  32  PC+4 of the instruction in ID.
- ifid_instr_o  out  32  instruction in ID.
- ifid_valid_o  out  1  ID holds a real instruction.
- idex_ctrl_o  out  CTRL_W  control bundle in EX.
- idex_valid_o  out  1  EX holds a real instruction.
- stall_cnt_o  out  CNT_W  count of stalled cycles.
- flush_cnt_o  out  CNT_W  count of IF/ID flushes.

Behaviour:
- Reset (asynchronous, takes effect immediately, independent of clk_i):
  - pc_o = RESET_PC.
  - ifid_pc4_o, ifid_instr_o, ifid_valid_o = 0.
  - idex_ctrl_o, idex_valid_o = 0.
  - Both counters = 0.
  - Reset asserted mid-stall or mid-flush discards all pending state; the first edge after release fetches RESET_PC.
- All non-reset updates occur on the rising clk_i edge. There is no combinational path from any input to any output.
- PC update, highest priority first:
  - branch_taken_i: pc_o <= branch_target_i. This overrides pcwrite_i = 0, because the branch is older than the load-use stall.
  - else pcwrite_i: pc_o <= pc_o + 4. Wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
  - else hold.
- IF/ID update, highest priority first:
  - ifid_flush_i: ifid_instr_o <= 32'h0 (NOP), ifid_pc4_o <= 0, ifid_valid_o <= 0. Flush beats ifid_write_i = 0.
  - else ifid_write_i: ifid_instr_o <= instr_i, ifid_pc4_o <= pc_o + 4, ifid_valid_o <= 1.
  - else hold all three.
- ID/EX control update:
  - idex_flush_i: idex_ctrl_o <= 0, idex_valid_o <= 0.
  - else idex_ctrl_o <= id_ctrl_i, idex_valid_o <= ifid_valid_o.
  - ID/EX has no hold; it is never write-disabled.
- stall_cnt_o increments by 1 on each edge where ifid_write_i = 0 and ifid_flush_i = 0.
- flush_cnt_o increments by 1 on each edge where ifid_flush_i = 1.
- Both counters saturate at all-ones and never wrap.
- Simultaneous load-use stall and branch (pcwrite_i = 0, ifid_write_i = 0, idex_flush_i = 1, ifid_flush_i = 1, branch_taken_i = 1):
  - PC redirects.
  - IF/ID flushes.
  - ID/EX gets a bubble.
  - stall_cnt_o unchanged; flush_cnt_o +1.
- Latency: a redirect is visible on pc_o one cycle after branch_taken_i is sampled. A fetched instruction appears on ifid_instr_o one edge after it is presented on instr_i.

Test Plan:
- Reset release with RESET_PC = 0 and all enables 1, instr_i = 32'h2008_0005 -> after edge 1: pc_o = 4, ifid_instr_o = 32'h2008_0005, ifid_pc4_o = 4, ifid_valid_o = 1.
- Load-use stall (pcwrite_i = 0, ifid_write_i = 0, idex_flush_i = 1) for 1 cycle at pc_o = 8 -> pc_o stays 8, IF/ID unchanged, idex_ctrl_o = 0, idex_valid_o = 0, stall_cnt_o = 1. The next cycle resumes with pc_o = 12.
- Branch with branch_target_i = 32'h40 and ifid_flush_i = 1 -> pc_o = 32'h40, ifid_instr_o = 0, ifid_valid_o = 0, flush_cnt_o +1. On the following edge idex_valid_o = 0.
- Stall and branch in the same cycle -> pc_o = branch target, IF/ID flushed, stall_cnt_o unchanged, flush_cnt_o +1.
- Assert rst_i asynchronously between edges during a stall -> all outputs return to reset values immediately, before the next edge. After release, pc_o = RESET_PC.
- Counter saturation with CNT_W = 4: hold ifid_write_i = 0 for 20 cycles -> stall_cnt_o = 4'hF and stays there. pc_o = 32'hFFFF_FFFC with pcwrite_i = 1 -> pc_o = 0.

Source files
------------

// File: rtl/if_id_pipe_ctrl.sv
// PC, IF/ID register and ID/EX control half for a 5-stage MIPS pipeline.
// Applies stall, flush and branch redirect, and keeps saturating stall/flush counters.
module if_id_pipe_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CTRL_W   = 10,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              pcwrite_i,
  input  logic              ifid_write_i,
  input  logic              ifid_flush_i,
  input  logic              idex_flush_i,
  input  logic              branch_taken_i,
  input  logic [31:0]       branch_target_i,
  input  logic [31:0]       instr_i,
  input  logic [CTRL_W-1:0] id_ctrl_i,
  output logic [31:0]       pc_o,
  output logic [31:0]       ifid_pc4_o,
  output logic [31:0]       ifid_instr_o,
  output logic              ifid_valid_o,
  output logic [CTRL_W-1:0] idex_ctrl_o,
  output logic              idex_valid_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  logic [31:0]       pc_q, pc_d;
  logic [31:0]       pc_plus4;
  logic [31:0]       ifid_pc4_q, ifid_pc4_d;
  logic [31:0]       ifid_instr_q, ifid_instr_d;
  logic              ifid_valid_q, ifid_valid_d;
  logic [CTRL_W-1:0] idex_ctrl_q, idex_ctrl_d;
  logic              idex_valid_q, idex_valid_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              stall_evt;

  assign pc_plus4  = pc_q + 32'd4;
  // A flushed IF/ID is a squash, not a stall, even when write is also disabled.
  assign stall_evt = ~ifid_write_i & ~ifid_flush_i;

  // The branch is older than any load-use stall, so it wins over pcwrite_i = 0.
  always_comb begin
    pc_d = pc_q;
    if (branch_taken_i) begin
      pc_d = branch_target_i;
    end else if (pcwrite_i) begin
      pc_d = pc_plus4;
    end
  end

  always_comb begin
    ifid_pc4_d   = ifid_pc4_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    if (ifid_flush_i) begin
      ifid_pc4_d   = 32'h0;
      ifid_instr_d = 32'h0;
      ifid_valid_d = 1'b0;
    end else if (ifid_write_i) begin
      ifid_pc4_d   = pc_plus4;
      ifid_instr_d = instr_i;
      ifid_valid_d = 1'b1;
    end
  end

  always_comb begin
    idex_ctrl_d  = id_ctrl_i;
    idex_valid_d = ifid_valid_q;
    if (idex_flush_i) begin
      idex_ctrl_d  = '0;
      idex_valid_d = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_evt && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (ifid_flush_i && !(&flush_cnt_q)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q         <= RESET_PC;
      ifid_pc4_q   <= 32'h0;
      ifid_instr_q <= 32'h0;
      ifid_valid_q <= 1'b0;
      idex_ctrl_q  <= '0;
      idex_valid_q <= 1'b0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      pc_q         <= pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
      idex_ctrl_q  <= idex_ctrl_d;
      idex_valid_q <= idex_valid_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign pc_o         = pc_q;
  assign ifid_pc4_o   = ifid_pc4_q;
  assign ifid_instr_o = ifid_instr_q;
  assign ifid_valid_o = ifid_valid_q;
  assign idex_ctrl_o  = idex_ctrl_q;
  assign idex_valid_o = idex_valid_q;
  assign stall_cnt_o  = stall_cnt_q;
  assign flush_cnt_o  = flush_cnt_q;

endmodule

// File: tb/tb_if_id_pipe_ctrl.sv
// Directed bench for if_id_pipe_ctrl: a default instance plus a CNT_W = 4 instance for saturation.
module tb_if_id_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pcwrite, ifid_write, ifid_flush, idex_flush, branch_taken;
  logic [31:0] branch_target, instr;
  logic [9:0]  id_ctrl;

  logic [31:0] pc, ifid_pc4, ifid_instr;
  logic        ifid_valid, idex_valid;
  logic [9:0]  idex_ctrl;
  logic [15:0] stall_cnt, flush_cnt;

  logic [31:0] s_pc, s_ifid_pc4, s_ifid_instr;
  logic        s_ifid_valid, s_idex_valid;
  logic [9:0]  s_idex_ctrl;
  logic [3:0]  s_stall_cnt, s_flush_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  if_id_pipe_ctrl #(.RESET_PC(32'h0), .CTRL_W(10), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .pcwrite_i(pcwrite), .ifid_write_i(ifid_write),
    .ifid_flush_i(ifid_flush), .idex_flush_i(idex_flush), .branch_taken_i(branch_taken),
    .branch_target_i(branch_target), .instr_i(instr), .id_ctrl_i(id_ctrl),
    .pc_o(pc), .ifid_pc4_o(ifid_pc4), .ifid_instr_o(ifid_instr), .ifid_valid_o(ifid_valid),
    .idex_ctrl_o(idex_ctrl), .idex_valid_o(idex_valid),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  if_id_pipe_ctrl #(.RESET_PC(32'h0000_0100), .CTRL_W(10), .CNT_W(4)) dut_sat (
    .clk_i(clk), .rst_i(rst), .pcwrite_i(pcwrite), .ifid_write_i(ifid_write),
    .ifid_flush_i(ifid_flush), .idex_flush_i(idex_flush), .branch_taken_i(branch_taken),
    .branch_target_i(branch_target), .instr_i(instr), .id_ctrl_i(id_ctrl),
    .pc_o(s_pc), .ifid_pc4_o(s_ifid_pc4), .ifid_instr_o(s_ifid_instr),
    .ifid_valid_o(s_ifid_valid), .idex_ctrl_o(s_idex_ctrl), .idex_valid_o(s_idex_valid),
    .stall_cnt_o(s_stall_cnt), .flush_cnt_o(s_flush_cnt)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_run;
    pcwrite = 1'b1; ifid_write = 1'b1; ifid_flush = 1'b0; idex_flush = 1'b0;
    branch_taken = 1'b0; branch_target = 32'h0;
  endtask

  task automatic test_reset;
    drive_run();
    instr = 32'h2008_0005; id_ctrl = 10'h155;
    #1;
    if (pc !== 32'h0) begin $display("FAIL rst_pc got %h want %h", pc, 32'h0); n_fail++; end
    n_cmp++;
    tick();
    if ({ifid_pc4, ifid_instr, ifid_valid} !== 65'h0) begin
      $display("FAIL rst_ifid got %h/%h/%b want 0", ifid_pc4, ifid_instr, ifid_valid); n_fail++;
    end
    n_cmp++;
    if ({idex_ctrl, idex_valid, stall_cnt, flush_cnt} !== 43'h0) begin
      $display("FAIL rst_idex_cnt got %h/%b/%h/%h want 0", idex_ctrl, idex_valid, stall_cnt,
               flush_cnt); n_fail++;
    end
    n_cmp++;
    if (s_pc !== 32'h100) begin $display("FAIL rst_pc_param got %h want 100", s_pc); n_fail++; end
    n_cmp++;
    #3 rst = 1'b0;
  endtask

  task automatic test_fetch;
    tick();
    if (pc !== 32'h4) begin $display("FAIL fetch1_pc got %h want 4", pc); n_fail++; end
    n_cmp++;
    if (ifid_instr !== 32'h2008_0005 || ifid_pc4 !== 32'h4 || ifid_valid !== 1'b1) begin
      $display("FAIL fetch1_ifid got %h/%h/%b want 20080005/4/1", ifid_instr, ifid_pc4,
               ifid_valid); n_fail++;
    end
    n_cmp++;
    if (idex_ctrl !== 10'h155 || idex_valid !== 1'b0) begin
      $display("FAIL fetch1_idex got %h/%b want 155/0", idex_ctrl, idex_valid); n_fail++;
    end
    n_cmp++;
    instr = 32'h8C09_0000; id_ctrl = 10'h0AA;
    tick();
    if (pc !== 32'h8 || ifid_instr !== 32'h8C09_0000 || ifid_pc4 !== 32'h8) begin
      $display("FAIL fetch2 got %h/%h/%h want 8/8c090000/8", pc, ifid_instr, ifid_pc4);
      n_fail++;
    end
    n_cmp++;
    if (idex_ctrl !== 10'h0AA || idex_valid !== 1'b1) begin
      $display("FAIL fetch2_idex got %h/%b want 0aa/1", idex_ctrl, idex_valid); n_fail++;
    end
    n_cmp++;
  endtask

  task automatic test_load_use_stall;
    pcwrite = 1'b0; ifid_write = 1'b0; idex_flush = 1'b1;
    instr = 32'h1111_1111; id_ctrl = 10'h3FF;
    tick();
    if (pc !== 32'h8) begin $display("FAIL stall_pc got %h want 8", pc); n_fail++; end
    n_cmp++;
    if (ifid_instr !== 32'h8C09_0000 || ifid_pc4 !== 32'h8 || ifid_valid !== 1'b1) begin
      $display("FAIL stall_ifid got %h/%h/%b want 8c090000/8/1", ifid_instr, ifid_pc4,
               ifid_valid); n_fail++;
    end
    n_cmp++;
    if (idex_ctrl !== 10'h0 || idex_valid !== 1'b0) begin
      $display("FAIL stall_bubble got %h/%b want 0/0", idex_ctrl, idex_valid); n_fail++;
    end
    n_cmp++;
    if (stall_cnt !== 16'd1) begin $display("FAIL stall_cnt got %0d want 1", stall_cnt); n_fail++; end
    n_cmp++;
    drive_run();
    instr = 32'h0128_5020; id_ctrl = 10'h003;
    tick();
    if (pc !== 32'hC || ifid_instr !== 32'h0128_5020 || ifid_pc4 !== 32'hC) begin
      $display("FAIL resume got %h/%h/%h want c/01285020/c", pc, ifid_instr, ifid_pc4);
      n_fail++;
    end
    n_cmp++;
    if (stall_cnt !== 16'd1 || idex_valid !== 1'b1 || idex_ctrl !== 10'h003) begin
      $display("FAIL resume_misc got %0d/%b/%h want 1/1/003", stall_cnt, idex_valid, idex_ctrl);
      n_fail++;
    end
    n_cmp++;
  endtask

  task automatic test_branch;
    branch_taken = 1'b1; branch_target = 32'h40; ifid_flush = 1'b1; instr = 32'h2222_2222;
    tick();
    if (pc !== 32'h40) begin $display("FAIL br_pc got %h want 40", pc); n_fail++; end
    n_cmp++;
    if (ifid_instr !== 32'h0 || ifid_pc4 !== 32'h0 || ifid_valid !== 1'b0) begin
      $display("FAIL br_ifid got %h/%h/%b want 0/0/0", ifid_instr, ifid_pc4, ifid_valid);
      n_fail++;
    end
    n_cmp++;
    if (flush_cnt !== 16'd1) begin $display("FAIL br_flush_cnt got %0d want 1", flush_cnt); n_fail++; end
    n_cmp++;
    drive_run();
    instr = 32'h3333_3333;
    tick();
    if (idex_valid !== 1'b0) begin $display("FAIL br_idex_valid got %b want 0", idex_valid); n_fail++; end
    n_cmp++;
    if (pc !== 32'h44 || ifid_instr !== 32'h3333_3333 || ifid_pc4 !== 32'h44) begin
      $display("FAIL br_refetch got %h/%h/%h want 44/33333333/44", pc, ifid_instr, ifid_pc4);
      n_fail++;
    end
    n_cmp++;
  endtask

  task automatic test_stall_and_branch;
    pcwrite = 1'b0; ifid_write = 1'b0; idex_flush = 1'b1; ifid_flush = 1'b1;
    branch_taken = 1'b1; branch_target = 32'h80; instr = 32'h4444_4444;
    tick();
    if (pc !== 32'h80) begin $display("FAIL sb_pc got %h want 80", pc); n_fail++; end
    n_cmp++;
    if (ifid_instr !== 32'h0 || ifid_valid !== 1'b0 || idex_valid !== 1'b0) begin
      $display("FAIL sb_flush got %h/%b/%b want 0/0/0", ifid_instr, ifid_valid, idex_valid);
      n_fail++;
    end
    n_cmp++;
    if (stall_cnt !== 16'd1 || flush_cnt !== 16'd2) begin
      $display("FAIL sb_cnt got %0d/%0d want 1/2", stall_cnt, flush_cnt); n_fail++;
    end
    n_cmp++;
  endtask

  task automatic test_pc_wrap;
    drive_run();
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC; instr = 32'h5555_5555;
    tick();
    if (pc !== 32'hFFFF_FFFC || ifid_pc4 !== 32'h84) begin
      $display("FAIL wrap_setup got %h/%h want fffffffc/84", pc, ifid_pc4); n_fail++;
    end
    n_cmp++;
    drive_run();
    tick();
    if (pc !== 32'h0 || ifid_pc4 !== 32'h0 || ifid_valid !== 1'b1) begin
      $display("FAIL wrap got %h/%h/%b want 0/0/1", pc, ifid_pc4, ifid_valid); n_fail++;
    end
    n_cmp++;
  endtask

  task automatic test_async_reset;
    pcwrite = 1'b0; ifid_write = 1'b0;
    tick();
    if (stall_cnt !== 16'd2) begin $display("FAIL ar_pre got %0d want 2", stall_cnt); n_fail++; end
    n_cmp++;
    #2 rst = 1'b1;
    #1;
    if (pc !== 32'h0 || ifid_valid !== 1'b0 || ifid_pc4 !== 32'h0 || ifid_instr !== 32'h0) begin
      $display("FAIL ar_ifid got %h/%b/%h/%h want 0", pc, ifid_valid, ifid_pc4, ifid_instr);
      n_fail++;
    end
    n_cmp++;
    if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0 || idex_valid !== 1'b0) begin
      $display("FAIL ar_cnt got %0d/%0d/%b want 0/0/0", stall_cnt, flush_cnt, idex_valid);
      n_fail++;
    end
    n_cmp++;
    #2 rst = 1'b0;
    drive_run();
    instr = 32'hAAAA_0001;
    tick();
    if (pc !== 32'h4 || ifid_instr !== 32'hAAAA_0001 || ifid_pc4 !== 32'h4) begin
      $display("FAIL ar_release got %h/%h/%h want 4/aaaa0001/4", pc, ifid_instr, ifid_pc4);
      n_fail++;
    end
    n_cmp++;
  endtask

  task automatic test_counter_saturation;
    ifid_write = 1'b0;
    repeat (15) tick();
    if (s_stall_cnt !== 4'hF) begin $display("FAIL sat15 got %h want f", s_stall_cnt); n_fail++; end
    n_cmp++;
    repeat (5) tick();
    if (s_stall_cnt !== 4'hF || stall_cnt !== 16'd20) begin
      $display("FAIL sat20 got %h/%0d want f/20", s_stall_cnt, stall_cnt); n_fail++;
    end
    n_cmp++;
    ifid_write = 1'b1; ifid_flush = 1'b1;
    repeat (17) tick();
    if (s_flush_cnt !== 4'hF || flush_cnt !== 16'd17 || s_stall_cnt !== 4'hF) begin
      $display("FAIL sat_flush got %h/%0d/%h want f/17/f", s_flush_cnt, flush_cnt, s_stall_cnt);
      n_fail++;
    end
    n_cmp++;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_load_use_stall();
    test_branch();
    test_stall_and_branch();
    test_pc_wrap();
    test_async_reset();
    test_counter_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
